// File: rtl/simon_pkg.sv
// simon_pkg
// Shared definitions for the Simon game controller: the controller state
// encoding, the four colour codes and the LFSR step used to draw new colours.
// No ports; imported by simon_lfsr and simon_sequencer.
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADD,
        PLAY_ON,
        PLAY_OFF,
        WAIT_PRESS,
        WAIT_RELEASE,
        CHECK,
        OVER,
        WIN
    } state_t;

    typedef logic [1:0] colour_t;

    localparam colour_t RED    = 2'd0;
    localparam colour_t GREEN  = 2'd1;
    localparam colour_t BLUE   = 2'd2;
    localparam colour_t YELLOW = 2'd3;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1: the bit shifted out
    // is folded back into positions 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
        return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/simon_if.sv
// simon_if
// Groups the game I/O of the Simon controller.
//   start          : one-clock pulse requesting a new game
//   player_num     : colour of the button currently held
//   player_pressed : debounced level, high while a button is held
//   simon_turn     : high while the controller plays the sequence back
//   simon_num      : colour being lit (0 when no lamp is lit)
//   simon_pressed  : lamp drive, high during the ON phase of playback
//   level          : current sequence length (LW bits)
//   game_over      : high once the player has lost
//   win            : high once the full-length sequence was echoed
// master = buttons/display side, slave = the controller.
interface simon_if #(parameter int LW = 5);

    logic          start;
    logic [1:0]    player_num;
    logic          player_pressed;
    logic          simon_turn;
    logic [1:0]    simon_num;
    logic          simon_pressed;
    logic [LW-1:0] level;
    logic          game_over;
    logic          win;

    modport master (
        output start, player_num, player_pressed,
        input  simon_turn, simon_num, simon_pressed, level, game_over, win
    );

    modport slave (
        input  start, player_num, player_pressed,
        output simon_turn, simon_num, simon_pressed, level, game_over, win
    );

endinterface

// File: rtl/simon_lfsr.sv
// simon_lfsr
// Free-running 8-bit Galois LFSR that supplies the colour of each new step.
//   clk    : game clock
//   reset  : asynchronous, active-high; loads SEED
//   lfsr_o : current 8-bit LFSR state
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;

    // Steps on every clock regardless of game state, so the colour drawn
    // depends on how long the player took; SEED must be non-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsrNext(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer
// Simon memory-game controller. Each round appends one random colour, plays
// the whole sequence back with fixed lamp on/off timing, then checks the
// player's echo press by press.
//   clk   : 60 Hz game clock
//   reset : asynchronous, active-high; aborts any game in progress
//   bus   : simon_if slave (start/player inputs, lamp/score outputs)
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter int         ON_TICKS      = 30,
    parameter int         OFF_TICKS     = 15,
    parameter int         TIMEOUT_TICKS = 300,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic    clk,
    input  logic    reset,
    simon_if.slave  bus
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (TIMEOUT_TICKS > ON_TICKS)
                          ? ((TIMEOUT_TICKS > OFF_TICKS) ? TIMEOUT_TICKS : OFF_TICKS)
                          : ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    colour_t       pnum_q, pnum_d;
    logic          prs_q;

    colour_t       mem [MAX_LEN];

    logic [7:0]    lfsrState;
    logic          unusedLfsrHi;
    logic          press;
    logic          lastStep;
    logic          memWe;

    simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsrState)
    );

    // Only the low two bits choose a colour; the rest are folded here so
    // they are visibly consumed.
    assign unusedLfsrHi = ^lfsrState[7:2];

    // A press counts only on the rising edge of the held level, so a button
    // still held from playback has to be released and pressed again.
    assign press    = bus.player_pressed & ~prs_q;
    assign lastStep = (LW'(idx_q) == (level_q - LW'(1)));

    // State and counter registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            pnum_q  <= RED;
            prs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            pnum_q  <= pnum_d;
            prs_q   <= bus.player_pressed;
        end
    end

    // Sequence store: deliberately not reset, entries beyond level are
    // never read so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[level_q[IW-1:0]] <= lfsrState[1:0];
        end
    end

    // Next-state logic. Timers count from 0 on entry to each timed state and
    // the state is left when the count reaches its limit minus one.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        pnum_d  = pnum_q;
        memWe   = 1'b0;

        case (state_q)
            IDLE, OVER, WIN: begin
                if (bus.start) begin
                    level_d = '0;
                    state_d = ADD;
                end
            end

            ADD: begin
                memWe   = 1'b1;
                level_d = level_q + 1'b1;
                idx_d   = '0;
                timer_d = '0;
                state_d = PLAY_ON;
            end

            PLAY_ON: begin
                if (timer_q == TW'(ON_TICKS - 1)) begin
                    timer_d = '0;
                    state_d = PLAY_OFF;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            PLAY_OFF: begin
                if (timer_q == TW'(OFF_TICKS - 1)) begin
                    timer_d = '0;
                    if (lastStep) begin
                        idx_d   = '0;
                        state_d = WAIT_PRESS;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = PLAY_ON;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WAIT_PRESS: begin
                // A press on the final allowed clock still wins over timeout.
                if (press) begin
                    pnum_d  = bus.player_num;
                    timer_d = '0;
                    state_d = WAIT_RELEASE;
                end else if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
                    state_d = OVER;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WAIT_RELEASE: begin
                if (!bus.player_pressed) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (pnum_q != mem[idx_q]) begin
                    state_d = OVER;
                end else if (lastStep) begin
                    state_d = (level_q == LW'(MAX_LEN)) ? WIN : ADD;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    timer_d = '0;
                    state_d = WAIT_PRESS;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registers. During ADD the level
    // already shows the length being built, so the display moves on in the
    // same clock the new round begins.
    always_comb begin
        bus.simon_turn    = (state_q == ADD) || (state_q == PLAY_ON) || (state_q == PLAY_OFF);
        bus.simon_pressed = (state_q == PLAY_ON);
        bus.simon_num     = (state_q == PLAY_ON) ? mem[idx_q] : RED;
        bus.level         = (state_q == ADD) ? (level_q + 1'b1) : level_q;
        bus.game_over     = (state_q == OVER);
        bus.win           = (state_q == WIN);
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer
// Directed bench for simon_sequencer: a full-size instance (MAX_LEN=16)
// covers playback timing, echo checking, timeout, held buttons, ignored
// start and mid-game reset; a MAX_LEN=2 instance covers the win path.
// Expected colours come from an independent bit-level model of the LFSR.
module tb_simon_sequencer;
    import simon_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    simon_if #(.LW(5)) busA ();
    simon_if #(.LW(2)) busB ();

    simon_sequencer #(
        .MAX_LEN(16), .ON_TICKS(30), .OFF_TICKS(15),
        .TIMEOUT_TICKS(300), .LFSR_SEED(8'hA5)
    ) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    simon_sequencer #(
        .MAX_LEN(2), .ON_TICKS(30), .OFF_TICKS(15),
        .TIMEOUT_TICKS(300), .LFSR_SEED(8'hA5)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    int         checks   = 0;
    int         failures = 0;
    int         timingErrs;
    logic [7:0] modelLfsr;
    colour_t    cols [16];
    colour_t    seen [16];

    // Polynomial x^8+x^6+x^5+x^4+1 written out bit by bit.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelLfsr <= 8'hA5;
        end else begin
            modelLfsr <= {modelLfsr[0], modelLfsr[7], modelLfsr[6] ^ modelLfsr[0],
                          modelLfsr[5] ^ modelLfsr[0], modelLfsr[4] ^ modelLfsr[0],
                          modelLfsr[3], modelLfsr[2], modelLfsr[1]};
        end
    end

    // Global time limit so a stuck run still ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Steps through n lamps starting from the ADD cycle, recording the colour
    // of each lamp and counting cycles off the 30-on/15-off schedule; ends
    // on the first WAIT_PRESS cycle.
    task automatic watch_playbackA(input int n);
        timingErrs = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 30; j++) begin
                tick();
                if (busA.simon_pressed !== 1'b1 || busA.simon_turn !== 1'b1) timingErrs++;
                if (j == 0) seen[i] = busA.simon_num;
                else if (busA.simon_num !== seen[i]) timingErrs++;
            end
            for (int j = 0; j < 15; j++) begin
                tick();
                if (busA.simon_pressed !== 1'b0 || busA.simon_turn !== 1'b1 ||
                    busA.simon_num !== 2'd0) timingErrs++;
            end
        end
        tick();
        if (busA.simon_turn !== 1'b0 || busA.simon_pressed !== 1'b0) timingErrs++;
    endtask

    task automatic pressA(input colour_t c, input int hold);
        busA.player_num     = c;
        busA.player_pressed = 1'b1;
        repeat (hold) tick();
        busA.player_pressed = 1'b0;
    endtask

    task automatic pressB(input colour_t c, input int hold);
        busB.player_num     = c;
        busB.player_pressed = 1'b1;
        repeat (hold) tick();
        busB.player_pressed = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (busA.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL reset_turn: got %b, expected 0", busA.simon_turn); end
        checks++; if (busA.simon_pressed !== 1'b0) begin failures++; $display("[TB] FAIL reset_pressed: got %b, expected 0", busA.simon_pressed); end
        checks++; if (busA.simon_num !== 2'd0) begin failures++; $display("[TB] FAIL reset_num: got %0d, expected 0", busA.simon_num); end
        checks++; if (busA.level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d, expected 0", busA.level); end
        checks++; if (busA.game_over !== 1'b0 || busA.win !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: got go=%b win=%b, expected 0 0", busA.game_over, busA.win); end
        reset = 1'b0;
        tick();
        checks++; if (busA.level !== 5'd0 || busA.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL idle_hold: got level=%0d turn=%b, expected 0 0", busA.level, busA.simon_turn); end
    endtask

    task automatic test_first_round();
        busA.start = 1'b1;
        tick();
        busA.start = 1'b0;
        checks++; if (busA.level !== 5'd1) begin failures++; $display("[TB] FAIL add_level: got %0d, expected 1", busA.level); end
        checks++; if (busA.simon_turn !== 1'b1 || busA.simon_pressed !== 1'b0) begin failures++; $display("[TB] FAIL add_outputs: got turn=%b pressed=%b, expected 1 0", busA.simon_turn, busA.simon_pressed); end
        cols[0] = modelLfsr[1:0];
        watch_playbackA(1);
        checks++; if (timingErrs !== 0) begin failures++; $display("[TB] FAIL round1_timing: got %0d bad cycles, expected 0", timingErrs); end
        checks++; if (seen[0] !== cols[0]) begin failures++; $display("[TB] FAIL round1_colour: got %0d, expected %0d", seen[0], cols[0]); end
        pressA(cols[0], 5);
        tick();
        checks++; if (busA.level !== 5'd1 || busA.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL check_cycle: got level=%0d turn=%b, expected 1 0", busA.level, busA.simon_turn); end
        tick();
        checks++; if (busA.level !== 5'd2 || busA.simon_turn !== 1'b1) begin failures++; $display("[TB] FAIL round2_add: got level=%0d turn=%b, expected 2 1", busA.level, busA.simon_turn); end
        cols[1] = modelLfsr[1:0];
        watch_playbackA(2);
        checks++; if (timingErrs !== 0) begin failures++; $display("[TB] FAIL round2_timing: got %0d bad cycles, expected 0", timingErrs); end
        checks++; if (seen[0] !== cols[0] || seen[1] !== cols[1]) begin failures++; $display("[TB] FAIL round2_colours: got %0d,%0d expected %0d,%0d", seen[0], seen[1], cols[0], cols[1]); end
    endtask

    task automatic test_wrong_press();
        pressA(cols[0], 3);
        tick();
        tick();
        pressA(cols[1] + 2'd1, 3);
        tick();
        checks++; if (busA.game_over !== 1'b0) begin failures++; $display("[TB] FAIL over_early: got %b, expected 0", busA.game_over); end
        tick();
        checks++; if (busA.game_over !== 1'b1 || busA.win !== 1'b0) begin failures++; $display("[TB] FAIL wrong_press: got go=%b win=%b, expected 1 0", busA.game_over, busA.win); end
        checks++; if (busA.level !== 5'd2 || busA.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL over_level: got level=%0d turn=%b, expected 2 0", busA.level, busA.simon_turn); end
    endtask

    task automatic test_restart();
        busA.start = 1'b1;
        tick();
        busA.start = 1'b0;
        checks++; if (busA.level !== 5'd1 || busA.game_over !== 1'b0) begin failures++; $display("[TB] FAIL restart: got level=%0d go=%b, expected 1 0", busA.level, busA.game_over); end
        cols[0] = modelLfsr[1:0];
        watch_playbackA(1);
        checks++; if (timingErrs !== 0 || seen[0] !== cols[0]) begin failures++; $display("[TB] FAIL restart_play: got errs=%0d colour=%0d, expected 0 %0d", timingErrs, seen[0], cols[0]); end
    endtask

    task automatic test_timeout();
        repeat (299) tick();
        checks++; if (busA.game_over !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %b, expected 0", busA.game_over); end
        tick();
        checks++; if (busA.game_over !== 1'b1 || busA.level !== 5'd1) begin failures++; $display("[TB] FAIL timeout: got go=%b level=%0d, expected 1 1", busA.game_over, busA.level); end
    endtask

    task automatic test_press_at_deadline();
        busA.start = 1'b1;
        tick();
        busA.start = 1'b0;
        cols[0] = modelLfsr[1:0];
        watch_playbackA(1);
        repeat (299) tick();
        pressA(cols[0], 1);
        checks++; if (busA.game_over !== 1'b0) begin failures++; $display("[TB] FAIL press_wins: got go=%b, expected 0", busA.game_over); end
        tick();
        tick();
        checks++; if (busA.level !== 5'd2 || busA.game_over !== 1'b0) begin failures++; $display("[TB] FAIL deadline_next: got level=%0d go=%b, expected 2 0", busA.level, busA.game_over); end
        cols[1] = modelLfsr[1:0];
    endtask

    task automatic test_held_button();
        busA.player_num     = cols[0] + 2'd1;
        busA.player_pressed = 1'b1;
        watch_playbackA(2);
        checks++; if (timingErrs !== 0 || seen[1] !== cols[1]) begin failures++; $display("[TB] FAIL held_play: got errs=%0d colour=%0d, expected 0 %0d", timingErrs, seen[1], cols[1]); end
        repeat (10) tick();
        busA.player_pressed = 1'b0;
        repeat (5) tick();
        checks++; if (busA.game_over !== 1'b0 || busA.level !== 5'd2) begin failures++; $display("[TB] FAIL held_no_edge: got go=%b level=%0d, expected 0 2", busA.game_over, busA.level); end
        pressA(cols[0], 2);
        tick();
        tick();
        pressA(cols[1], 2);
        tick();
        tick();
        checks++; if (busA.level !== 5'd3 || busA.simon_turn !== 1'b1) begin failures++; $display("[TB] FAIL held_repress: got level=%0d turn=%b, expected 3 1", busA.level, busA.simon_turn); end
    endtask

    task automatic test_start_ignored_and_reset();
        repeat (5) tick();
        busA.start = 1'b1;
        tick();
        busA.start = 1'b0;
        checks++; if (busA.level !== 5'd3 || busA.simon_pressed !== 1'b1 || busA.simon_num !== cols[0]) begin failures++; $display("[TB] FAIL start_ignored: got level=%0d pressed=%b num=%0d, expected 3 1 %0d", busA.level, busA.simon_pressed, busA.simon_num, cols[0]); end
        tick();
        checks++; if (busA.simon_pressed !== 1'b1 || busA.level !== 5'd3) begin failures++; $display("[TB] FAIL start_ignored2: got pressed=%b level=%0d, expected 1 3", busA.simon_pressed, busA.level); end
        reset = 1'b1;
        #1;
        checks++; if (busA.simon_pressed !== 1'b0 || busA.level !== 5'd0 || busA.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset: got pressed=%b level=%0d turn=%b, expected 0 0 0", busA.simon_pressed, busA.level, busA.simon_turn); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (busA.simon_turn !== 1'b0 || busA.level !== 5'd0) begin failures++; $display("[TB] FAIL post_reset_idle: got turn=%b level=%0d, expected 0 0", busA.simon_turn, busA.level); end
    endtask

    task automatic test_win();
        colour_t c0;
        colour_t c1;
        busB.start = 1'b1;
        tick();
        busB.start = 1'b0;
        c0 = modelLfsr[1:0];
        checks++; if (busB.level !== 2'd1) begin failures++; $display("[TB] FAIL win_add1: got %0d, expected 1", busB.level); end
        tick();
        checks++; if (busB.simon_pressed !== 1'b1 || busB.simon_num !== c0) begin failures++; $display("[TB] FAIL win_lamp: got pressed=%b num=%0d, expected 1 %0d", busB.simon_pressed, busB.simon_num, c0); end
        repeat (45) tick();
        checks++; if (busB.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL win_wait1: got turn=%b, expected 0", busB.simon_turn); end
        pressB(c0, 2);
        tick();
        tick();
        checks++; if (busB.level !== 2'd2) begin failures++; $display("[TB] FAIL win_add2: got %0d, expected 2", busB.level); end
        c1 = modelLfsr[1:0];
        repeat (91) tick();
        checks++; if (busB.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL win_wait2: got turn=%b, expected 0", busB.simon_turn); end
        pressB(c0, 2);
        tick();
        tick();
        pressB(c1, 2);
        tick();
        tick();
        checks++; if (busB.win !== 1'b1 || busB.game_over !== 1'b0) begin failures++; $display("[TB] FAIL win_flag: got win=%b go=%b, expected 1 0", busB.win, busB.game_over); end
        checks++; if (busB.level !== 2'd2 || busB.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL win_level: got level=%0d turn=%b, expected 2 0", busB.level, busB.simon_turn); end
        repeat (3) tick();
        checks++; if (busB.win !== 1'b1 || busB.simon_turn !== 1'b0) begin failures++; $display("[TB] FAIL win_hold: got win=%b turn=%b, expected 1 0", busB.win, busB.simon_turn); end
    endtask

    // Scenarios run back to back on one continuous game history.
    initial begin
        busA.start = 1'b0; busA.player_num = RED; busA.player_pressed = 1'b0;
        busB.start = 1'b0; busB.player_num = RED; busB.player_pressed = 1'b0;
        test_reset();
        test_first_round();
        test_wrong_press();
        test_restart();
        test_timeout();
        test_press_at_deadline();
        test_held_button();
        test_start_ignored_and_reset();
        test_win();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
Game controller for the Simon memory game, clocked at 60 Hz. It grows a random colour sequence one step per round and plays it back, one lamp at a time, with fixed on/off timing. It then checks the player's echo press by press and reports game over, win and the current level. It sits between the 4-button/4-lamp I/O and the display/score logic.

Parameters:
MAX_LEN, 16, maximum sequence length; reaching it and echoing correctly is a win
ON_TICKS, 30, clocks a lamp is lit during playback
OFF_TICKS, 15, dark clocks after each playback lamp
TIMEOUT_TICKS, 300, clocks allowed between player presses (5 s) before game over
LFSR_SEED, 8'hA5, non-zero LFSR value loaded at reset

Ports:
clk  in  1  60 Hz game clock
reset  in  1  asynchronous, active-high
start  in  1  one-clock pulse; begins a new game from IDLE, OVER or WIN; ignored elsewhere
player_num  in  2  colour of the button currently pressed
player_pressed  in  1  level signal, high while a button is held (already debounced)
simon_turn  out  1  high while the controller is playing back the sequence
simon_num  out  2  colour being played; valid when simon_pressed=1, 0 otherwise
simon_pressed  out  1  lamp drive, high during the ON phase of playback
level  out  LW  current sequence length, LW=$clog2(MAX_LEN+1)
game_over  out  1  high in OVER
win  out  1  high in WIN

Behaviour:
- Reset (async): state IDLE; all outputs 0; level=0; idx=0; timer=0; LFSR=LFSR_SEED; press-edge register cleared. Reset mid-game aborts immediately with no further lamp activity.
- Outputs are a decode of the state/idx registers; no added latency.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, advances every clock in every state. New step = lfsr[1:0].
- Sequence store: MAX_LEN x 2-bit register array, not cleared on reset.
- Press edge: prs_q <= player_pressed every clock; press = player_pressed & ~prs_q.
- States:
  - IDLE: outputs 0. start -> ADD with level=0.
  - ADD: mem[level] <= lfsr[1:0]; level <= level+1; idx=0; timer=0 -> PLAY_ON. simon_turn=1.
  - PLAY_ON: simon_turn=1, simon_pressed=1, simon_num=mem[idx] for exactly ON_TICKS clocks -> PLAY_OFF.
  - PLAY_OFF: simon_turn=1 for OFF_TICKS clocks. If idx==level-1: idx=0, timer=0 -> WAIT_PRESS. Otherwise idx+1 -> PLAY_ON.
  - WAIT_PRESS: simon_turn=0; timer increments. On press: latch player_num into pnum, timer=0 -> WAIT_RELEASE. If timer==TIMEOUT_TICKS-1 with no press -> OVER.
  - WAIT_RELEASE: wait for player_pressed==0 (no timeout) -> CHECK.
  - CHECK (1 clock): pnum!=mem[idx] -> OVER. Otherwise, if idx==level-1: level==MAX_LEN -> WIN, else -> ADD. Otherwise idx+1, timer=0 -> WAIT_PRESS.
  - OVER: game_over=1; level holds. start -> ADD with level=0, game_over drops.
  - WIN: win=1; level=MAX_LEN holds. start behaves as in OVER.
- Presses during playback are ignored. A button held from playback into WAIT_PRESS produces no edge; it must be released and pressed again.
- A press and a timeout on the same clock: the press wins.
- start outside IDLE/OVER/WIN is ignored.

Decomposition:
- Package simon_pkg: state enum (IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_PRESS, WAIT_RELEASE, CHECK, OVER, WIN); colour constants RED=0, GREEN=1, BLUE=2, YELLOW=3.
- Sub-module simon_lfsr: seed parameter, 8-bit state out, free-running.

Test Plan:
- Reset, then start pulse at cycle 0 -> level=1 and simon_turn=1 from cycle 1; simon_pressed high for cycles 2..31; dark for cycles 32..46; simon_turn=0 from cycle 47.
- Echo the played colour (hold 5 clocks, release) -> CHECK one clock after release is seen, then level=2. Playback shows 2 lamps; the first equals the round-1 colour.
- Press (simon_num+1)%4 in round 1 -> game_over=1 two clocks after release; win=0; level=1 holds; next start -> level=1, game_over=0.
- No press for 300 clocks in WAIT_PRESS -> game_over=1. A press at clock 299 -> no game over.
- MAX_LEN=2 build, echo both rounds correctly -> win=1, level=2, simon_turn=0, no third ADD.
- Hold a button from PLAY_ON into WAIT_PRESS -> no check occurs until release and re-press. Assert reset during PLAY_ON -> simon_pressed=0 and level=0 in the same cycle.
